// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial slice adder controller.
package serial_add_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for NSLICES slices; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester/consumer handshake bundle for serial_add_ctrl.
// The sub select exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(parameter int NSLICES = 4);
  import serial_add_pkg::*;

  localparam int W = SLICE_W * NSLICES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output start_valid, a, b, cin, res_ready,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  start_ready, res_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  start_valid, a, b, cin, res_ready,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output start_ready, res_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/slice_adder3.sv
// Combinational 3-bit ripple-carry slice shared across all operand slices.
module slice_adder3 (
  output logic       carry_out,
  output logic [2:0] s,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       carry_in
);

  logic [3:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carry_out = c[3];

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequences one 3-bit slice adder over NSLICES slices to add W-bit operands.
// Optional subtract mode is enabled with SERIAL_ADD_SUB_EN.
//
// state | meaning
// IDLE  | ready for a new operation, operands captured on accept
// RUN   | one slice added per cycle, carry held between slices
// DONE  | result presented until the consumer takes it
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NSLICES = 4
) (
  input logic               clk,
  input logic               rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int W     = SLICE_W * NSLICES;
  localparam int IDX_W = clog2(NSLICES);

  state_t             state, state_n;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       b_eff;
  logic               cin_eff;
  logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
  logic               c_sl;
  logic               last;

`ifdef SERIAL_ADD_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  assign last = (idx == IDX_W'(NSLICES - 1));
  assign a_sl = a_q[SLICE_W*int'(idx) +: SLICE_W];
  assign b_sl = b_q[SLICE_W*int'(idx) +: SLICE_W];

  slice_adder3 u_slice (
    .carry_out (c_sl),
    .s         (s_sl),
    .a         (a_sl),
    .b         (b_sl),
    .carry_in  (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start_valid) state_n = RUN;
      RUN:     if (last)            state_n = DONE;
      DONE:    if (bus.res_ready)   state_n = IDLE;
      default:                      state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q   <= bus.a;
            b_q   <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
            sum_q <= '0;
          end
        end
        RUN: begin
          sum_q[SLICE_W*int'(idx) +: SLICE_W] <= s_sl;
          carry <= c_sl;
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Flags are decoded from registers only and gated so they read 0 outside DONE.
  assign bus.start_ready = (state == IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.sum         = sum_q;
  assign bus.cout        = (state == DONE) & carry;
  assign bus.ovf         = (state == DONE) & (a_q[W-1] == b_q[W-1]) & (sum_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl with NSLICES=4 (12-bit words).
module tb_serial_add_ctrl;

  localparam int NS = 4;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  serial_add_ctrl_if #(.NSLICES(NS)) bus ();

  serial_add_ctrl #(.NSLICES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [11:0] av, input logic [11:0] bv, input logic cv, input logic sv);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.a   = av;
    bus.b   = bv;
    bus.cin = cv;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sv;
`else
    if (sv) $display("[TB] sub requested without SERIAL_ADD_SUB_EN");
`endif
    @(negedge clk);
    bus.start_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge; returns edges until res_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [11:0] es, input logic ec, input logic eo);
    tests_run++;
    if (bus.sum !== es || bus.cout !== ec || bus.ovf !== eo) begin
      tests_failed++;
      $display("FAIL %s: sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               name, bus.sum, bus.cout, bus.ovf, es, ec, eo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sum !== 12'h000 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b valid=%b busy=%b sum=%h cout=%b ovf=%b, expected 1 0 0 000 0 0",
               bus.start_ready, bus.res_valid, bus.busy, bus.sum, bus.cout, bus.ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    start_op(12'h001, 12'h001, 1'b0, 1'b0);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy: busy=%b ready=%b, expected busy=1 ready=0", bus.busy, bus.start_ready);
    end
    wait_done(lat);
    tests_run++;
    if (lat !== NS) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d cycles, expected %0d", lat, NS);
    end
    check_result("basic_add", 12'h002, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_wrap();
    int lat;
    start_op(12'hFFF, 12'h001, 1'b0, 1'b0);
    wait_done(lat);
    tests_run++;
    if (lat !== NS) begin
      tests_failed++;
      $display("FAIL wrap_latency: got %0d cycles, expected %0d", lat, NS);
    end
    check_result("full_wrap", 12'h000, 1'b1, 1'b0);
    drain();
    start_op(12'h5A5, 12'h3C3, 1'b1, 1'b0);
    wait_done(lat);
    // two positives giving a negative result also flag overflow
    check_result("mixed_cin", 12'h969, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_overflow();
    int lat;
    start_op(12'h7FF, 12'h001, 1'b0, 1'b0);
    wait_done(lat);
    check_result("ovf_pos", 12'h800, 1'b0, 1'b1);
    drain();
    start_op(12'h800, 12'h800, 1'b0, 1'b0);
    wait_done(lat);
    check_result("ovf_neg", 12'h000, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_handshake();
    int lat;
    start_op(12'h123, 12'h456, 1'b0, 1'b0);
    bus.start_valid = 1'b1;
    bus.a   = 12'hFFF;
    bus.b   = 12'hFFF;
    bus.cin = 1'b1;
    tests_run++;
    if (bus.start_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_ready: start_ready=%b, expected 0", bus.start_ready);
    end
    wait_done(lat);
    tests_run++;
    if (lat !== NS) begin
      tests_failed++;
      $display("FAIL hs_latency: got %0d cycles, expected %0d", lat, NS);
    end
    check_result("hs_result", 12'h579, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.start_ready !== 1'b0 || bus.sum !== 12'h579 || bus.cout !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_%0d: valid=%b ready=%b sum=%h cout=%b, expected 1 0 579 0",
                 i, bus.res_valid, bus.start_ready, bus.sum, bus.cout);
      end
    end
    bus.res_ready = 1'b1;
    tests_run++;
    if (bus.start_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_ready: start_ready=%b with res_ready high, expected 0", bus.start_ready);
    end
    @(negedge clk);
    bus.res_ready   = 1'b0;
    bus.start_valid = 1'b0;
    tests_run++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_release: ready=%b valid=%b busy=%b, expected 1 0 0",
               bus.start_ready, bus.res_valid, bus.busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_no_capture: busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(12'h111, 12'h222, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.sum !== 12'h000 || bus.start_ready !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: valid=%b sum=%h ready=%b busy=%b, expected 0 000 1 0",
               bus.res_valid, bus.sum, bus.start_ready, bus.busy);
    end
    start_op(12'h002, 12'h003, 1'b0, 1'b0);
    wait_done(lat);
    tests_run++;
    if (lat !== NS) begin
      tests_failed++;
      $display("FAIL post_reset_latency: got %0d cycles, expected %0d", lat, NS);
    end
    check_result("post_reset_add", 12'h005, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int first, second, cyc;
    first  = -1;
    second = -1;
    @(negedge clk);
    bus.a = 12'h010;
    bus.b = 12'h020;
    bus.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    bus.start_valid = 1'b1;
    bus.res_ready   = 1'b1;
    for (cyc = 0; cyc < 20 && second < 0; cyc++) begin
      if (bus.start_ready) begin
        if (first < 0) first = cyc;
        else           second = cyc;
      end
      if (bus.res_valid) begin
        tests_run++;
        if (bus.sum !== 12'h030) begin
          tests_failed++;
          $display("FAIL b2b_sum: got %h expected 030", bus.sum);
        end
      end
      @(negedge clk);
    end
    bus.start_valid = 1'b0;
    tests_run++;
    if (second - first !== NS + 2) begin
      tests_failed++;
      $display("FAIL b2b_period: got %0d cycles, expected %0d", second - first, NS + 2);
    end
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
    bus.res_ready = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: busy=%b expected 0", bus.busy);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int lat;
    start_op(12'h005, 12'h007, 1'b0, 1'b1);
    wait_done(lat);
    check_result("sub_borrow", 12'hFFE, 1'b0, 1'b0);
    drain();
    start_op(12'h007, 12'h005, 1'b0, 1'b1);
    wait_done(lat);
    check_result("sub_no_borrow", 12'h002, 1'b1, 1'b0);
    drain();
  endtask
`endif

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.cin         = 1'b0;
    bus.res_ready   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub         = 1'b0;
`endif
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_handshake();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
